// File: rtl/knob_encoder_counter_if.sv
// ---------------------------------------------------------------------------
// knob_encoder_counter_if
// Bundles the encoder inputs, counter configuration and value outputs of
// knob_encoder_counter.
//   master : drives en, rot_a/b/center, start_value, step, limits, wrap_mode;
//            observes out, changed, dir, at_limit
//   slave  : the counter itself (mirror image of master)
// ---------------------------------------------------------------------------
interface knob_encoder_counter_if #(
    parameter int WIDTH = 12
);
    logic             en;
    logic             rot_a;
    logic             rot_b;
    logic             rot_center;
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] lower_limit;
    logic [WIDTH-1:0] upper_limit;
    logic             wrap_mode;
    logic [WIDTH-1:0] out;
    logic             changed;
    logic             dir;
    logic             at_limit;

    modport master (
        output en, rot_a, rot_b, rot_center, start_value, step,
               lower_limit, upper_limit, wrap_mode,
        input  out, changed, dir, at_limit
    );

    modport slave (
        input  en, rot_a, rot_b, rot_center, start_value, step,
               lower_limit, upper_limit, wrap_mode,
        output out, changed, dir, at_limit
    );
endinterface

// File: rtl/knob_encoder_counter.sv
// ---------------------------------------------------------------------------
// knob_encoder_counter
// Rotary-encoder value counter for front-panel controls. Raw A/B/centre inputs
// are synchronised, debounced, and A/B decoded into detents by a 4-state
// machine. Each detent steps a WIDTH-bit value between runtime limits,
// saturating or wrapping; the centre button reloads start_value.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : knob_encoder_counter_if.slave (encoder inputs, configuration,
//                out / changed / dir / at_limit)
//
// Build option: define KNOB_ACCEL_EN to multiply the step by
// 2**ACCEL_SHIFT when detents arrive less than ACCEL_WINDOW cycles apart.
// ---------------------------------------------------------------------------
module knob_encoder_counter #(
    parameter int WIDTH           = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACCEL_WINDOW    = 50000,
    parameter int ACCEL_SHIFT     = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    knob_encoder_counter_if.slave bus
);
    // Arithmetic width: room for the shifted step plus a carry bit.
    localparam int AW  = WIDTH + ACCEL_SHIFT + 1;
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CW1  = 2'b01;
    localparam logic [1:0] ST_CCW1 = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] lo,
                                               input logic [WIDTH-1:0] hi);
        logic [WIDTH-1:0] m;
        m = (x < lo) ? lo : x;
        return (m > hi) ? hi : m;
    endfunction

    // ---------------- synchroniser + debounce (bit 2 = C, 1 = B, 0 = A) ----
    logic [2:0]     raw;
    logic [2:0]     sync_q [SYNC_STAGES];
    logic [2:0]     synced;
    logic [2:0]     filt_q;
    logic [DCW-1:0] deb_cnt_q [3];

    assign raw    = {bus.rot_center, bus.rot_b, bus.rot_a};
    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // synchroniser chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
            filt_q <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            for (int i = 0; i < 3; i++) begin
                if (synced[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    filt_q[i]    <= synced[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ---------------- quadrature decoder ----------------------------------
    logic [1:0] ab;
    logic       centre;
    logic [1:0] state_q, state_d;
    logic       det_up, det_dn;

    assign ab     = {filt_q[0], filt_q[1]};   // {A,B}
    assign centre = filt_q[2];

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        det_up  = 1'b0;
        det_dn  = 1'b0;
        if (bus.en) begin
            if (ab == 2'b00) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ab == 2'b01)      state_d = ST_CW1;
                        else if (ab == 2'b10) state_d = ST_CCW1;
                        else                  state_d = ST_DONE;  // lost detent
                    end
                    ST_CW1: begin
                        if (ab == 2'b10) state_d = ST_CCW1;
                        else if (ab == 2'b11) begin
                            state_d = ST_DONE;
                            det_up  = 1'b1;
                        end
                    end
                    ST_CCW1: begin
                        if (ab == 2'b01) state_d = ST_CW1;
                        else if (ab == 2'b11) begin
                            state_d = ST_DONE;
                            det_dn  = 1'b1;
                        end
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            // Centre press wins over a detent completing in the same cycle.
            if (centre) begin
                state_d = ST_DONE;
                det_up  = 1'b0;
                det_dn  = 1'b0;
            end
        end
    end

    // ---------------- optional acceleration -------------------------------
    logic fast;
`ifdef KNOB_ACCEL_EN
    localparam int ACW = $clog2(ACCEL_WINDOW + 1);
    localparam logic [ACW-1:0] ACC_MAX = ACW'(ACCEL_WINDOW);
    logic [ACW-1:0] acc_q;

    // Reset to the saturated value so the first detent is always slow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                acc_q <= ACC_MAX;
        else if (det_up || det_dn) acc_q <= '0;
        else if (acc_q != ACC_MAX) acc_q <= acc_q + 1'b1;
    end
    assign fast = (acc_q != ACC_MAX);
`else
    assign fast = 1'b0;
`endif

    // ---------------- value arithmetic ------------------------------------
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             changed_q;
    logic             load_pending_q;
    logic             limits_ok;
    logic [AW-1:0]    base_w, step_w, eff_w, lo_w, hi_w;

    assign limits_ok = (bus.lower_limit <= bus.upper_limit);
    assign lo_w      = {{(AW-WIDTH){1'b0}}, bus.lower_limit};
    assign hi_w      = {{(AW-WIDTH){1'b0}}, bus.upper_limit};
    assign step_w    = {{(AW-WIDTH){1'b0}}, bus.step};
    assign eff_w     = fast ? (step_w << ACCEL_SHIFT) : step_w;
    // A count left outside freshly changed limits is clamped before stepping.
    assign base_w    = {{(AW-WIDTH){1'b0}},
                        clamp(count_q, bus.lower_limit, bus.upper_limit)};

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        if (load_pending_q) begin
            count_d = clamp(bus.start_value, bus.lower_limit, bus.upper_limit);
        end else if (bus.en && limits_ok) begin
            if (centre) begin
                count_d = clamp(bus.start_value, bus.lower_limit, bus.upper_limit);
            end else if (det_up) begin
                dir_d = 1'b1;
                if (bus.step != '0) begin
                    if (base_w + eff_w <= hi_w) count_d = base_w[WIDTH-1:0] + eff_w[WIDTH-1:0];
                    else if (bus.wrap_mode)     count_d = bus.lower_limit;
                    else                        count_d = bus.upper_limit;
                end
            end else if (det_dn) begin
                dir_d = 1'b0;
                if (bus.step != '0) begin
                    if (base_w >= lo_w + eff_w) count_d = base_w[WIDTH-1:0] - eff_w[WIDTH-1:0];
                    else if (bus.wrap_mode)     count_d = bus.upper_limit;
                    else                        count_d = bus.lower_limit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            dir_q          <= 1'b0;
            changed_q      <= 1'b0;
            load_pending_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            dir_q          <= dir_d;
            changed_q      <= (count_d != count_q);
            load_pending_q <= 1'b0;
        end
    end

    assign bus.out      = count_q;
    assign bus.changed  = changed_q;
    assign bus.dir      = dir_q;
    assign bus.at_limit = (count_q == bus.lower_limit) || (count_q == bus.upper_limit);
endmodule
